pam4_sym_src: RTL

Upstream source for the SRRC transmit filter. Generates the sample and symbol clock enables and one 18-bit 4-PAM symbol per symbol period. Symbols come from a 22-bit PRBS or from one of three deterministic test patterns. Every symbol-rate consumer, the TX filter first, takes its `sam_clk_en`/`sym_clk_en` and `sym_out` from this block.

---
 rtl/pam4_sym_src_pkg.sv | 30 +++
 rtl/pam4_sym_src_lfsr22_2step.sv | 19 +
 rtl/pam4_sym_src.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pam4_sym_src_pkg.sv
// Shared symbol levels, mode encodings and Gray mapping for the 4-PAM source
// and any symbol-rate consumer that needs to interpret its output.
package pam4_sym_src_pkg;

    typedef enum logic [1:0] {
        MODE_PRBS    = 2'd0,
        MODE_IMPULSE = 2'd1,
        MODE_DC      = 2'd2,
        MODE_ALT     = 2'd3
    } mode_e;

    localparam logic signed [17:0] SYMBOL_N2 = -18'sd98304;
    localparam logic signed [17:0] SYMBOL_N1 = -18'sd32768;
    localparam logic signed [17:0] SYMBOL_P1 = 18'sd32768;
    localparam logic signed [17:0] SYMBOL_P2 = 18'sd98304;

    // Gray-coded bit pair to level, adjacent levels differ in one bit
    function automatic logic signed [17:0] gray_level(input logic [1:0] bits);
        logic signed [17:0] level;
        case (bits)
            2'b00:   level = SYMBOL_N2;
            2'b01:   level = SYMBOL_N1;
            2'b11:   level = SYMBOL_P1;
            2'b10:   level = SYMBOL_P2;
            default: level = SYMBOL_N2;
        endcase
        return level;
    endfunction

endpackage

// File: rtl/pam4_sym_src_lfsr22_2step.sv
// Combinational two-step advance of the 22-bit PRBS (x^22 + x^21 + 1).
// Shared with the receive-side BER checker so both ends step identically.
module lfsr22_2step (
    input  logic [21:0] state,
    output logic [21:0] next_state,
    output logic [1:0]  fb_pair
);

    logic        fb1_s;
    logic        fb2_s;
    logic [21:0] step1_s;

    assign fb1_s      = state[21] ^ state[20];
    assign step1_s    = {state[20:0], fb1_s};
    assign fb2_s      = step1_s[21] ^ step1_s[20];
    assign next_state = {step1_s[20:0], fb2_s};
    assign fb_pair    = {fb1_s, fb2_s};

endmodule

// File: rtl/pam4_sym_src.sv
// Sample/symbol strobe generator and 4-PAM symbol source (PRBS or test patterns)
// feeding the SRRC transmit filter and other symbol-rate consumers.
module pam4_sym_src
    import pam4_sym_src_pkg::*;
#(
    parameter int          SAM_DIV        = 4,
    parameter logic [21:0] LFSR_SEED      = 22'h3FFFFF,
    parameter int          IMPULSE_PERIOD = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [1:0]         mode,
    output logic               sam_clk_en,
    output logic               sym_clk_en,
    output logic signed [17:0] sym_out,
    output logic [1:0]         sym_bits
);

    localparam int DIV_W = (SAM_DIV > 1) ? $clog2(SAM_DIV) : 1;
    localparam int IMP_W = $clog2(IMPULSE_PERIOD);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAM_DIV - 1);
    localparam logic [IMP_W-1:0] IMP_LAST = IMP_W'(IMPULSE_PERIOD - 1);

    logic [DIV_W-1:0]   div_cnt_r;
    logic [1:0]         sam_cnt_r;
    logic [IMP_W-1:0]   imp_cnt_r;
    logic               phase_r;
    logic [21:0]        lfsr_r;
    mode_e              mode_r;
    logic               sam_clk_en_r;
    logic               sym_clk_en_r;
    logic signed [17:0] sym_out_r;
    logic [1:0]         sym_bits_r;

    logic               div_wrap_s;
    mode_e              mode_s;
    logic [21:0]        lfsr_next_s;
    logic [1:0]         fb_pair_s;
    logic [IMP_W-1:0]   imp_base_s;
    logic               phase_base_s;
    logic signed [17:0] nxt_out_s;
    logic [1:0]         nxt_bits_s;
    logic [IMP_W-1:0]   nxt_imp_s;
    logic               nxt_phase_s;
    logic [21:0]        nxt_lfsr_s;

    lfsr22_2step u_lfsr (
        .state      (lfsr_r),
        .next_state (lfsr_next_s),
        .fb_pair    (fb_pair_s)
    );

    assign div_wrap_s = (div_cnt_r == DIV_LAST);

    // Next symbol for the pattern selected now; pattern counters restart on mode entry
    always_comb begin
        mode_s       = mode_e'(mode);
        imp_base_s   = (mode_r == MODE_IMPULSE) ? imp_cnt_r : {IMP_W{1'b0}};
        phase_base_s = (mode_r == MODE_ALT) ? phase_r : 1'b0;
        nxt_out_s    = SYMBOL_P2;
        nxt_bits_s   = 2'b00;
        nxt_imp_s    = imp_cnt_r;
        nxt_phase_s  = phase_r;
        nxt_lfsr_s   = lfsr_r;
        case (mode_s)
            MODE_PRBS: begin
                nxt_lfsr_s = lfsr_next_s;
                nxt_bits_s = fb_pair_s;
                nxt_out_s  = gray_level(fb_pair_s);
            end
            MODE_IMPULSE: begin
                nxt_out_s = (imp_base_s == {IMP_W{1'b0}}) ? SYMBOL_P2 : 18'sd0;
                nxt_imp_s = (imp_base_s == IMP_LAST) ? {IMP_W{1'b0}}
                                                     : imp_base_s + IMP_W'(1'b1);
            end
            MODE_DC: begin
                nxt_out_s = SYMBOL_P2;
            end
            MODE_ALT: begin
                nxt_out_s   = phase_base_s ? SYMBOL_N2 : SYMBOL_P2;
                nxt_phase_s = ~phase_base_s;
            end
            default: begin
                nxt_out_s = SYMBOL_P2;
            end
        endcase
    end

    // Strobe generator: counters advance only on enabled cycles
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt_r    <= {DIV_W{1'b0}};
            sam_cnt_r    <= 2'd0;
            sam_clk_en_r <= 1'b0;
            sym_clk_en_r <= 1'b0;
        end else if (enable) begin
            div_cnt_r    <= div_wrap_s ? {DIV_W{1'b0}} : div_cnt_r + DIV_W'(1'b1);
            sam_cnt_r    <= div_wrap_s ? sam_cnt_r + 2'd1 : sam_cnt_r;
            sam_clk_en_r <= div_wrap_s;
            sym_clk_en_r <= div_wrap_s && (sam_cnt_r == 2'd0);
        end else begin
            sam_clk_en_r <= 1'b0;
            sym_clk_en_r <= 1'b0;
        end
    end

    // Symbol register: an emitted symbol strobe always commits its symbol so
    // consumers never see a strobe without a matching update
    always_ff @(posedge clk) begin
        if (!reset) begin
            imp_cnt_r  <= {IMP_W{1'b0}};
            phase_r    <= 1'b0;
            lfsr_r     <= LFSR_SEED;
            mode_r     <= MODE_PRBS;
            sym_out_r  <= 18'sd0;
            sym_bits_r <= 2'b00;
        end else if (sym_clk_en_r) begin
            imp_cnt_r  <= nxt_imp_s;
            phase_r    <= nxt_phase_s;
            lfsr_r     <= nxt_lfsr_s;
            mode_r     <= mode_s;
            sym_out_r  <= nxt_out_s;
            sym_bits_r <= nxt_bits_s;
        end else begin
            sym_out_r  <= sym_out_r;
            sym_bits_r <= sym_bits_r;
        end
    end

    assign sam_clk_en = sam_clk_en_r;
    assign sym_clk_en = sym_clk_en_r;
    assign sym_out    = sym_out_r;
    assign sym_bits   = sym_bits_r;

endmodule
